div_host_if: RTL

DIV_HOST_IF -- requirements
Module: div_host_if

---
 rtl/div_host_pkg.sv | 20 ++
 rtl/div_piso.sv | 29 ++
 rtl/div_host_if.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_host_pkg.sv
// Shared types and default sizing for the serial-divider host interface.
package div_host_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 40;
   localparam int LOAD_CYCLES = DEF_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      COLLECT,
      RESULT
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/div_piso.sv
// Parallel-load, hold/shift-enable shift register presenting its MSB for serial output.
module div_piso
   import div_host_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= data;
      end else if (shift) begin
         sreg <= sreg << 1;
      end
   end

   assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/div_host_if.sv
// Host-side handshake wrapper around a bit-serial divider: serialises N/D, collects Q.
// Optional macro DIV_HOST_DIVZERO_CHECK_EN answers D==0 locally without using the divider.
module div_host_if
   import div_host_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_n,
   input  logic [WIDTH-1:0] in_d,
   output logic             div_load,
   output logic             div_n,
   output logic             div_d,
   input  logic             div_done,
   input  logic             div_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic             out_err
);

   // The package constant is sized for the default width; rebase it on this instance.
   localparam int LOAD_LEN = LOAD_CYCLES + (WIDTH - DEF_WIDTH);
   localparam int CNT_MAX  = max2(LOAD_LEN, max2(TIMEOUT, WIDTH));
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_shift_in;
   logic             err_reg;
   logic             err_next;
   logic             armed;
   logic             piso_load;
   logic             piso_shift;
   logic             n_msb;
   logic             d_msb;

   div_piso #(.WIDTH(WIDTH)) u_piso_n (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (piso_load),
      .shift   (piso_shift),
      .data    (in_n),
      .msb     (n_msb)
   );

   div_piso #(.WIDTH(WIDTH)) u_piso_d (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (piso_load),
      .shift   (piso_shift),
      .data    (in_d),
      .msb     (d_msb)
   );

   // Keeps in_ready low until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         q_reg   <= '0;
         err_reg <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         q_reg   <= q_next;
         err_reg <= err_next;
      end
   end

   assign q_shift_in = (q_reg << 1) | WIDTH'(div_q);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      q_next     = q_reg;
      err_next   = err_reg;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      in_ready   = 1'b0;
      div_load   = 1'b0;
      out_valid  = 1'b0;

      case (state)
         IDLE: begin
            in_ready = armed;
            if (in_valid && armed) begin
               piso_load  = 1'b1;
               q_next     = '0;
               err_next   = 1'b0;
               cnt_next   = '0;
               state_next = LOAD;
`ifdef DIV_HOST_DIVZERO_CHECK_EN
               if (in_d == '0) begin
                  q_next     = '1;
                  err_next   = 1'b1;
                  state_next = RESULT;
               end
`endif
            end
         end

         // MSB is presented twice (first two cycles), so the LSB lands on the last load cycle.
         LOAD: begin
            div_load   = 1'b1;
            piso_shift = (cnt != '0) && (cnt != LOAD_LAST);
            if (cnt == LOAD_LAST) begin
               cnt_next   = '0;
               state_next = WAIT;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         // The bit present when div_done first rises is the quotient MSB and is captured here.
         WAIT: begin
            if (div_done) begin
               q_next     = q_shift_in;
               cnt_next   = CNT_W'(1);
               state_next = (WIDTH == 1) ? RESULT : COLLECT;
            end else if (cnt == WAIT_LAST) begin
               q_next     = '1;
               err_next   = 1'b1;
               state_next = RESULT;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         COLLECT: begin
            if (div_done) begin
               q_next = q_shift_in;
               if (cnt == CAPT_LAST) begin
                  state_next = RESULT;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end else begin
               err_next   = 1'b1;
               state_next = RESULT;
            end
         end

         RESULT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign div_n   = (state == LOAD) & n_msb;
   assign div_d   = (state == LOAD) & d_msb;
   assign out_q   = q_reg;
   assign out_err = err_reg;

endmodule
